serial_tx_fifo: RTL and testbench

Byte FIFO that sits directly upstream of the serial transmitter and feeds its data/send/ready handshake.
- Host logic pushes bytes with a single-cycle write strobe at any rate, up to the FIFO depth.
- The FIFO presents the head byte to the transmitter and pops it on the edge where the transmitter takes it over, so back-to-back bytes go out without gaps.
- Sits between the system bus or command logic and the UART transmit path.

---
 rtl/serial_tx_fifo.sv | 114 +++++++++++
 tb/tb_serial_tx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the serial transmitter's data/send/ready handshake.
// Head byte is presented first-word fall-through; pop happens on the edge
// where the transmitter accepts it (oTxSend & iTxReady).
// Optional macro SERIAL_TX_FIFO_OVERFLOW_EN enables the sticky oOverflow flag.
module serial_tx_fifo #(
    parameter  int unsigned Depth      = 16,
    localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic [7:0]            iData,
    input  logic                  iWrite,
    input  logic                  iFlush,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic [CountWidth-1:0] oCount,
    output logic [7:0]            oTxData,
    output logic                  oTxSend,
    input  logic                  iTxReady,
    output logic                  oOverflow,
    input  logic                  iClearOverflow
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [7:0]            mem_q [Depth];
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic                  push_c, pop_c;

    // Accepted push and pop for this edge; flush overrides both.
    always_comb begin
        push_c = iWrite & ~full_q & ~iFlush;
        pop_c  = ~empty_q & iTxReady & ~iFlush;
    end

    // Next-state for pointers, occupancy and status flags.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iFlush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CountWidth'(1);
                2'b01:   count_d = count_q - CountWidth'(1);
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CountWidth'(Depth));
    end

`ifdef SERIAL_TX_FIFO_OVERFLOW_EN
    // Sticky drop flag: set beats clear, flush leaves it alone.
    always_comb begin
        ovf_d = ovf_q;
        if (iClearOverflow)      ovf_d = 1'b0;
        if (iWrite && full_q)    ovf_d = 1'b1;
    end
`else
    logic unused_clear_c;

    // Feature disabled: flag stays low and the clear input is ignored.
    always_comb begin
        ovf_d          = 1'b0;
        unused_clear_c = iClearOverflow;
    end
`endif

    // Control state with asynchronous reset.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage, intentionally not reset.
    always_ff @(posedge iClock) begin
        if (push_c) mem_q[wr_ptr_q] <= iData;
    end

    // Outputs taken straight from registered state.
    always_comb begin
        oFull     = full_q;
        oEmpty    = empty_q;
        oCount    = count_q;
        oTxSend   = ~empty_q;
        oTxData   = mem_q[rd_ptr_q];
        oOverflow = ovf_q;
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_serial_tx_fifo;

    localparam int unsigned Depth = 16;
    localparam int unsigned CW    = $clog2(Depth + 1);
`ifdef SERIAL_TX_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    data;
    logic          wr, flush, rdy, clr;
    logic          full, empty, send, ovf;
    logic [CW-1:0] count;
    logic [7:0]    txd;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq [$];
    logic       m_ovf;

    always #5 clk = ~clk;

    serial_tx_fifo #(.Depth(Depth)) dut (
        .iClock(clk), .iReset_n(rst_n), .iData(data), .iWrite(wr),
        .iFlush(flush), .oFull(full), .oEmpty(empty), .oCount(count),
        .oTxData(txd), .oTxSend(send), .iTxReady(rdy),
        .oOverflow(ovf), .iClearOverflow(clr)
    );

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rdy;
        logic       flush;
        int         cnt;
        logic       send;
        logic [7:0] txd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference update from the rules: flush clears, pop takes head, push appends if room.
    task automatic model_edge();
        int sz;
        sz = mq.size();
        if (OVF_EN) begin
            if (wr && sz == Depth) m_ovf = 1'b1;
            else if (clr)          m_ovf = 1'b0;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && rdy) void'(mq.pop_front());
            if (wr && sz < Depth) mq.push_back(data);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, ".full"},  32'(full),  32'(mq.size() == Depth));
        check({tag, ".send"},  32'(send),  32'(mq.size() != 0));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        if (mq.size() != 0) check({tag, ".data"}, 32'(txd), 32'(mq[0]));
    endtask

    // Apply inputs at a falling edge, step one rising edge, return at the next falling edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic f, input logic c);
        wr = w; data = d; rdy = r; flush = f; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        wr = 1'b0; rdy = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
        vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 2, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h5A};
        vecs[3] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h11};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 8'h33, 1'b0, 1'b0, 1, 1'b1, 8'h33};
        vecs[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b1, 8'h44};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00};

        rst_n = 1'b0; wr = 1'b0; data = 8'h00; flush = 1'b0; rdy = 1'b0; clr = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle with ready high.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("idle.empty", 32'(empty), 32'd1);
            check("idle.full",  32'(full),  32'd0);
            check("idle.count", 32'(count), 32'd0);
            check("idle.send",  32'(send),  32'd0);
            check("idle.ovf",   32'(ovf),   32'd0);
        end

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].wr, vecs[i].data, vecs[i].rdy, vecs[i].flush, 1'b0);
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.send", i),  32'(send),  32'(vecs[i].send));
            if (vecs[i].send) check($sformatf("vec%0d.data", i), 32'(txd), 32'(vecs[i].txd));
        end

        // Single byte through with ready held high.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        check("single.send", 32'(send), 32'd1);
        check("single.data", 32'(txd),  32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("single.count", 32'(count), 32'd0);
        check("single.send0", 32'(send),  32'd0);

        // Fill to full, drop one, then drain slowly.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("fill.count", 32'(count), 32'd16);
        check("fill.full",  32'(full),  32'd1);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("drop.count", 32'(count), 32'd16);
        check("drop.ovf",   32'(ovf),   32'(OVF_EN));
        for (int i = 0; i < 16; i++) begin
            repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("drain.data", 32'(txd), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        compare_all("drained");
        check("drained.empty", 32'(empty), 32'd1);

        // Preload three, then push and pop every edge across several wraps.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            check("wrap.head", 32'(txd), 32'(8'(8'h80 + k)));
            cycle(1'b1, 8'(8'h83 + k), 1'b1, 1'b0, 1'b0);
            check("wrap.count", 32'(count), 32'd3);
        end
        compare_all("wrap");

        // Flush with a concurrent write: both discarded, overflow untouched.
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        check("preflush.count", 32'(count), 32'd5);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("flush.count", 32'(count), 32'd0);
        check("flush.empty", 32'(empty), 32'd1);
        check("flush.send",  32'(send),  32'd0);
        check("flush.ovf",   32'(ovf),   32'(OVF_EN));
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clear.ovf", 32'(ovf), 32'd0);

        // Asynchronous reset between edges with eight queued.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        check("prerst.count", 32'(count), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        check("arst.send",  32'(send),  32'd0);
        check("arst.count", 32'(count), 32'd0);
        check("arst.empty", 32'(empty), 32'd1);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("postrst.send", 32'(send), 32'd1);
        check("postrst.data", 32'(txd),  32'h3C);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0));
            compare_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
